// File: rtl/irq_nest_ctrl.sv
// Nested interrupt controller: a LIFO of active {id,prio} entries raises the
// effective threshold so that only more urgent sources can preempt a running handler.
module irq_nest_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_req_i,
    input  logic [7:0]  irq_id_i,
    input  logic [7:0]  irq_prio_i,
    output logic        irq_o,
    output logic [7:0]  irq_id_o,
    input  logic        irq_ack_i,
    input  logic        mret_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  be_i,
    input  logic        we_i,
    output logic [31:0] data_o
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        nest_en_q, nest_en_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        err_q, err_d;
    logic [31:0] ackcnt_q, ackcnt_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  irq_id_q, irq_id_d;
    logic [7:0]  pend_prio_q, pend_prio_d;
    logic [2:0]  depth_q, depth_d;
    logic [7:0]  stack_id_q   [DEPTH];
    logic [7:0]  stack_id_d   [DEPTH];
    logic [7:0]  stack_prio_q [DEPTH];
    logic [7:0]  stack_prio_d [DEPTH];

    logic [2:0]  top_idx;
    logic [2:0]  wr_idx;
    logic [7:0]  top_id;
    logic [7:0]  top_prio;
    logic [7:0]  eff_thr;
    logic        eligible;
    logic        ack_take;
    logic        pop;
    logic        wr_ctrl, wr_thresh, wr_stat, wr_ackcnt;
    logic        unused_ok;

    assign unused_ok = ^{addr_i[31:8], data_i[31:25], data_i[23:8], be_i[2:1]};

    assign irq_o    = (state_q == PEND);
    assign irq_id_o = irq_id_q;
    assign data_o   = data_q;

    assign wr_ctrl   = we_i && (addr_i[7:0] == 8'h00);
    assign wr_thresh = we_i && (addr_i[7:0] == 8'h04);
    assign wr_stat   = we_i && (addr_i[7:0] == 8'h08);
    assign wr_ackcnt = we_i && (addr_i[7:0] == 8'h0C);

    assign top_idx  = depth_q - 3'd1;
    assign ack_take = (state_q == PEND) && irq_ack_i;
    assign pop      = mret_i && (depth_q != 3'd0);

    always_comb begin
        top_id   = 8'h00;
        top_prio = 8'h00;
        if (depth_q != 3'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == top_idx) begin
                    top_id   = stack_id_q[i];
                    top_prio = stack_prio_q[i];
                end
            end
        end
    end

    // A running handler masks everything not strictly more urgent than itself.
    always_comb begin
        if (depth_q == 3'd0) begin
            eff_thr = thresh_q;
        end else begin
            eff_thr = (top_prio > thresh_q) ? top_prio : thresh_q;
        end
        eligible = en_q && irq_req_i && (irq_prio_i > eff_thr)
                   && ((depth_q == 3'd0) || nest_en_q)
                   && (depth_q < 3'(DEPTH));
    end

    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        pend_prio_d  = pend_prio_q;
        depth_d      = depth_q;
        stack_id_d   = stack_id_q;
        stack_prio_d = stack_prio_q;
        en_d         = en_q;
        nest_en_d    = nest_en_q;
        thresh_d     = thresh_q;
        err_d        = err_q;
        ackcnt_d     = ackcnt_q;
        data_d       = 32'h0;
        wr_idx       = depth_q;

        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d     = PEND;
                    irq_id_d    = irq_id_i;
                    pend_prio_d = irq_prio_i;
                end
            end
            PEND: begin
                if (irq_ack_i) begin
                    state_d = IDLE;
                end else if (eligible) begin
                    irq_id_d    = irq_id_i;
                    pend_prio_d = irq_prio_i;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == top_idx) begin
                    stack_id_d[i]   = 8'h00;
                    stack_prio_d[i] = 8'h00;
                end
            end
            depth_d = depth_q - 3'd1;
        end

        // With a same-cycle mret the acked entry lands in the slot just vacated.
        if (ack_take && (pop || (depth_q < 3'(DEPTH)))) begin
            wr_idx = pop ? top_idx : depth_q;
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == wr_idx) begin
                    stack_id_d[i]   = irq_id_q;
                    stack_prio_d[i] = pend_prio_q;
                end
            end
            depth_d = pop ? depth_q : depth_q + 3'd1;
        end

        if (wr_ctrl && be_i[0]) begin
            en_d      = data_i[0];
            nest_en_d = data_i[1];
        end
        if (wr_thresh && be_i[0]) begin
            thresh_d = data_i[7:0];
        end
        if (wr_stat && be_i[3] && data_i[24]) begin
            err_d = 1'b0;
        end
        if (mret_i && (depth_q == 3'd0)) begin
            err_d = 1'b1;
        end

        if (wr_ackcnt) begin
            ackcnt_d = 32'h0;
        end else if (ack_take) begin
            ackcnt_d = ackcnt_q + 32'd1;
        end

        unique case (addr_i[7:0])
            8'h00:   data_d = {30'h0, nest_en_q, en_q};
            8'h04:   data_d = {24'h0, thresh_q};
            8'h08:   data_d = {7'h0, err_q, 5'h0, depth_q, top_prio, top_id};
            8'h0C:   data_d = ackcnt_q;
            default: data_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            irq_id_q    <= 8'h00;
            pend_prio_q <= 8'h00;
            depth_q     <= 3'd0;
            en_q        <= 1'b0;
            nest_en_q   <= 1'b0;
            thresh_q    <= 8'h00;
            err_q       <= 1'b0;
            ackcnt_q    <= 32'h0;
            data_q      <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_id_q[i]   <= 8'h00;
                stack_prio_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            irq_id_q    <= irq_id_d;
            pend_prio_q <= pend_prio_d;
            depth_q     <= depth_d;
            en_q        <= en_d;
            nest_en_q   <= nest_en_d;
            thresh_q    <= thresh_d;
            err_q       <= err_d;
            ackcnt_q    <= ackcnt_d;
            data_q      <= data_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_id_q[i]   <= stack_id_d[i];
                stack_prio_q[i] <= stack_prio_d[i];
            end
        end
    end

endmodule

// File: doc/irq_nest_ctrl.md
IRQ_NEST_CTRL -- requirements
Module: irq_nest_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning maximum interrupt nesting levels (stack entries), range 1..7.
REQ-002 SHALL have clk_i  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have irq_req_i  input  1  winning request valid from the interrupt controller.
REQ-005 SHALL have irq_id_i  input  8  id of the winning source.
REQ-006 SHALL have irq_prio_i  input  8  priority of the winning source (larger = more urgent).
REQ-007 SHALL have irq_o  output  1  interrupt request to core.
REQ-008 SHALL have irq_id_o  output  8  id presented with irq_o.
REQ-009 SHALL have irq_ack_i  input  1  core took the trap for irq_id_o this cycle.
REQ-010 SHALL have mret_i  input  1  core completed the innermost handler.
REQ-011 SHALL have addr_i  input  32, data_i  input  32, be_i  input  4, we_i  input  1, data_o  output  32: register bus with byte enables.

Function
REQ-012 SHALL decode registers on addr_i[7:0]: 0x0 CTRL ([0] en, [1] nest_en, rw), 0x4 THRESH ([7:0], rw), 0x8 STAT (ro: [7:0] top id, [15:8] top prio, [18:16] depth, [24] err), 0xC ACKCNT (32-bit).
REQ-013 SHALL honour be_i per byte on rw writes; unimplemented bits read 0.
REQ-014 SHALL clear STAT.err on a write to 0x8 with be_i[3]=1 and data_i[24]=1; other STAT bits ignore writes.
REQ-015 SHALL clear ACKCNT on any write to 0xC; otherwise increment by 1 per accepted ack, wrapping 0xFFFFFFFF->0.
REQ-016 SHALL return data_o registered one cycle after addr_i; unmapped offsets read 0.
REQ-017 SHALL keep a LIFO stack of DEPTH {id,prio} entries and a depth counter 0..DEPTH.
REQ-018 SHALL compute eff_thr = THRESH when depth==0, else max(THRESH, top prio).
REQ-019 SHALL define eligible = en & irq_req_i & (irq_prio_i > eff_thr) & (depth==0 | nest_en) & (depth<DEPTH); comparison strictly greater.
REQ-020 SHALL implement FSM IDLE/PEND; irq_o=1 exactly when state is PEND.
REQ-021 IDLE: eligible -> PEND next edge, irq_id_o loaded with irq_id_i (1-cycle latency), prio latched internally.
REQ-022 PEND, irq_ack_i=1 -> push latched {id,prio}, depth+1, ACKCNT+1, -> IDLE (irq_o low next cycle).
REQ-023 PEND, no ack, eligible -> stay PEND, irq_id_o/prio reload from current inputs (tracks new winner).
REQ-024 PEND, no ack, not eligible -> IDLE (request withdrawn), stack unchanged.
REQ-025 mret_i with depth>0 SHALL pop top entry, depth-1; with depth==0 SHALL be ignored and set STAT.err.
REQ-026 Simultaneous ack and mret (depth>0) SHALL pop then push: depth unchanged, top replaced by acked entry, ACKCNT+1.
REQ-027 irq_ack_i in IDLE SHALL be ignored (no push, no count).
REQ-028 Eligibility SHALL use stack/THRESH state of the current cycle; writes to CTRL/THRESH take effect the following cycle.
REQ-029 Clearing CTRL.en while PEND SHALL withdraw irq_o next cycle; stack contents preserved.

Reset
REQ-030 Reset SHALL force state IDLE, irq_o=0, irq_id_o=0, data_o=0, depth=0, stack entries 0, CTRL=0, THRESH=0, err=0, ACKCNT=0.
REQ-031 Reset assertion mid-PEND or mid-nest SHALL immediately drop irq_o and discard stack, independent of clk_i.

Verification
REQ-032 en=1, THRESH=3, req id=5 prio=4 -> irq_o=1, irq_id_o=5 next cycle; ack -> STAT depth=1 top prio=4, ACKCNT=1.
REQ-033 depth=1 top prio=4, nest_en=0, req prio=9 -> irq_o stays 0; set nest_en=1 -> irq_o=1; ack -> depth=2; mret -> depth=1 top prio=4.
REQ-034 PEND on id=5 prio=4, then req id=7 prio=6 before ack -> irq_id_o=7; req dropped -> irq_o=0 next cycle, depth unchanged.
REQ-035 DEPTH=4 stack full, req prio=0xFF -> irq_o=0; mret with depth=0 -> STAT.err=1, cleared by writing 0x0100_0000 to 0x8.
REQ-036 depth=2 PEND, ack and mret same cycle -> depth=2, top id = acked id; rst_ni low mid-PEND -> irq_o=0 at once, all registers 0.
